jellyvl_etherneco_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single Etherneco ring transmit byte stream between N frame requesters. It grants one requester at a time and forwards its frame byte-for-byte with one register stage. It enforces a minimum inter-frame gap and aborts stalled frames with a forced terminator. It sits in front of the ring TX PHY. Its output carries the same first/last/data/valid framing that the ring receiver parses.

---
 rtl/jellyvl_etherneco_pkg.sv | 17 +
 rtl/jellyvl_etherneco_rr_select.sv | 36 +++
 rtl/jellyvl_etherneco_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_jellyvl_etherneco_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jellyvl_etherneco_pkg.sv
// Shared definitions for the Etherneco ring transmit path.
//   arb_state_t        : state of the TX arbiter FSM
//   DEFAULT_IFG_CYCLES : idle cycles inserted after each frame
//   DEFAULT_TIMEOUT    : stall cycles tolerated while a requester holds the grant
package jellyvl_etherneco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no grant, waiting for any request
        ST_GRANT   = 2'd1,  // granted, waiting for the first byte of the frame
        ST_FORWARD = 2'd2,  // forwarding frame bytes
        ST_GAP     = 2'd3   // enforcing the inter-frame gap
    } arb_state_t;

    localparam int DEFAULT_IFG_CYCLES = 12;
    localparam int DEFAULT_TIMEOUT    = 1023;

endpackage

// File: rtl/jellyvl_etherneco_rr_select.sv
// Combinational N-way round-robin pick.
// The first requester after 'last' (wrapping) with its req bit set wins.
//   req   : request vector
//   last  : index of the previous winner
//   grant : one-hot winner (all zero when nothing is requested)
//   index : binary index of the winner (0 when nothing is requested)
module jellyvl_etherneco_rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic found;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        // Walk distances 1..N from the last winner; both loops unroll to constant indices.
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && ((int'(last) + k) % N) == i) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    index    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/jellyvl_etherneco_tx_arbiter.sv
// Round-robin arbiter sharing the ring TX byte stream between N requesters.
// One requester is granted at a time; its frame is forwarded through one register
// stage. Stalled frames are aborted with a forced terminator byte, a first-flag in
// mid-frame is treated as a protocol error, and an inter-frame gap follows every frame.
//   reset, clk          : asynchronous active-low reset, clock
//   s_req               : per-requester frame request (level)
//   s_grant             : registered one-hot grant
//   s_ready             : s_grant while waiting for or forwarding a frame
//   s_first/s_last      : per-requester frame delimiters
//   s_data              : per-requester byte, requester i at [8i+7:8i]
//   s_valid             : per-requester byte strobe
//   m_first/m_last/m_data/m_valid : output byte stream (downstream always accepts)
//   busy                : arbiter not idle
//   abort               : one-cycle pulse on timeout or protocol error
module jellyvl_etherneco_tx_arbiter
    import jellyvl_etherneco_pkg::*;
#(
    parameter int N          = 2,
    parameter int IFG_CYCLES = DEFAULT_IFG_CYCLES,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic           reset,
    input  logic           clk,
    input  logic [N-1:0]   s_req,
    output logic [N-1:0]   s_grant,
    output logic [N-1:0]   s_ready,
    input  logic [N-1:0]   s_first,
    input  logic [N-1:0]   s_last,
    input  logic [N*8-1:0] s_data,
    input  logic [N-1:0]   s_valid,
    output logic           m_first,
    output logic           m_last,
    output logic [7:0]     m_data,
    output logic           m_valid,
    output logic           busy,
    output logic           abort
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(IFG_CYCLES);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_last;
    logic [IDLE_W-1:0] idle_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [N-1:0]      pick_grant;
    logic [IDX_W-1:0]  pick_idx;

    logic              granted;
    logic              is_fwd;
    logic              sel_valid;
    logic              sel_first;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              accept;
    logic              timeout;
    logic              emit_byte;
    logic              emit_term;
    logic              frame_end;
    logic              raise_abort;

    jellyvl_etherneco_rr_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (s_req),
        .last  (rr_last),
        .grant (pick_grant),
        .index (pick_idx)
    );

    assign granted = (state == ST_GRANT) || (state == ST_FORWARD);
    assign is_fwd  = (state == ST_FORWARD);
    assign s_ready = granted ? s_grant : '0;
    assign busy    = (state != ST_IDLE);

    // One-hot input mux driven by the registered grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_first = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (s_grant[i]) begin
                sel_valid = s_valid[i];
                sel_first = s_first[i];
                sel_last  = s_last[i];
                sel_data  = s_data[8*i +: 8];
            end
        end
    end

    // An accepted byte wins over a timeout that matures in the same cycle.
    assign accept  = granted && sel_valid;
    assign timeout = granted && !accept && (idle_cnt == IDLE_MAX);

    // GRANT forwards only a first byte; FORWARD forwards anything but a first byte.
    assign emit_byte   = accept && (is_fwd ? !sel_first : sel_first);
    // Terminator only when a frame was already started on the output.
    assign emit_term   = is_fwd && ((accept && sel_first) || timeout);
    assign raise_abort = (is_fwd && accept && sel_first) || timeout;
    assign frame_end   = (accept && sel_last && (is_fwd || sel_first))
                       || (is_fwd && accept && sel_first)
                       || timeout;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            s_grant  <= '0;
            rr_last  <= IDX_W'(N - 1);
            idle_cnt <= '0;
            gap_cnt  <= '0;
            m_valid  <= 1'b0;
            m_first  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= 8'h00;
            abort    <= 1'b0;
        end else begin
            m_valid <= emit_byte || emit_term;
            abort   <= raise_abort;

            // Output fields hold their value while m_valid is low.
            if (emit_byte) begin
                m_first <= !is_fwd;
                m_last  <= sel_last;
                m_data  <= sel_data;
            end else if (emit_term) begin
                m_first <= 1'b0;
                m_last  <= 1'b1;
                m_data  <= 8'h00;
            end

            case (state)
                ST_IDLE: begin
                    if (|s_req) begin
                        s_grant  <= pick_grant;
                        rr_last  <= pick_idx;
                        idle_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end

                ST_GRANT, ST_FORWARD: begin
                    if (frame_end) begin
                        s_grant  <= '0;
                        idle_cnt <= '0;
                        if (IFG_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end else begin
                        // Never exceeds IDLE_MAX: reaching it ends the frame above.
                        if (accept) begin
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                        if (!is_fwd && accept && sel_first) begin
                            state <= ST_FORWARD;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt > GAP_W'(1)) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jellyvl_etherneco_tx_arbiter.sv
// Self-checking bench for jellyvl_etherneco_tx_arbiter (N=2, IFG=12, TIMEOUT=1023).
// A frame-level reference model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations; a randomized phase follows.
module tb_jellyvl_etherneco_tx_arbiter;

    localparam int N   = 2;
    localparam int IFG = 12;
    localparam int TMO = 1023;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   s_req   = '0;
    logic [N-1:0]   s_first = '0;
    logic [N-1:0]   s_last  = '0;
    logic [N-1:0]   s_valid = '0;
    logic [8*N-1:0] s_data  = '0;
    logic [N-1:0]   s_grant;
    logic [N-1:0]   s_ready;
    logic           m_first;
    logic           m_last;
    logic [7:0]     m_data;
    logic           m_valid;
    logic           busy;
    logic           abort;

    jellyvl_etherneco_tx_arbiter #(
        .N          (N),
        .IFG_CYCLES (IFG),
        .TIMEOUT    (TMO)
    ) dut (
        .reset   (reset),
        .clk     (clk),
        .s_req   (s_req),
        .s_grant (s_grant),
        .s_ready (s_ready),
        .s_first (s_first),
        .s_last  (s_last),
        .s_data  (s_data),
        .s_valid (s_valid),
        .m_first (m_first),
        .m_last  (m_last),
        .m_data  (m_data),
        .m_valid (m_valid),
        .busy    (busy),
        .abort   (abort)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int         owner;     // granted requester, -1 when none
    bit         started;   // first byte of the current frame already sent
    int         stall;     // consecutive granted cycles without a byte
    int         gap_left;  // remaining gap cycles
    int         rr;        // last winner
    logic       exp_mv, exp_mf, exp_ml, exp_ab;
    logic [7:0] exp_md;

    task automatic model_reset();
        owner = -1; started = 0; stall = 0; gap_left = 0; rr = N - 1;
        exp_mv = 0; exp_mf = 0; exp_ml = 0; exp_ab = 0; exp_md = 8'h00;
    endtask

    task automatic emit(input bit f, input bit l, input logic [7:0] d);
        exp_mv = 1; exp_mf = f; exp_ml = l; exp_md = d;
    endtask

    task automatic finish_frame();
        owner = -1; started = 0; stall = 0; gap_left = IFG;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        exp_mv = 0;
        exp_ab = 0;
        if (owner >= 0) begin
            if (s_valid[owner]) begin
                stall = 0;
                if (!started) begin
                    if (s_first[owner]) begin
                        emit(1, s_last[owner], s_data[8*owner +: 8]);
                        if (s_last[owner]) finish_frame();
                        else started = 1;
                    end
                end else if (s_first[owner]) begin
                    emit(0, 1, 8'h00);
                    exp_ab = 1;
                    finish_frame();
                end else begin
                    emit(0, s_last[owner], s_data[8*owner +: 8]);
                    if (s_last[owner]) finish_frame();
                end
            end else if (stall == TMO) begin
                if (started) emit(0, 1, 8'h00);
                exp_ab = 1;
                finish_frame();
            end else begin
                stall++;
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (rr + k) % N;
                if (s_req[c]) begin
                    owner = c; rr = c; started = 0; stall = 0;
                    break;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [N-1:0] g;
        logic         b;
        g = '0;
        if (owner >= 0) g[owner] = 1'b1;
        b = (owner >= 0) || (gap_left > 0);
        return 32'({g, g, b, exp_ab, exp_mv, exp_mf, exp_ml, exp_md});
    endfunction

    // Continuous comparison, sampled away from the active edge.
    always @(negedge clk) begin
        if (cmp_en)
            check("outputs", 32'({s_grant, s_ready, busy, abort, m_valid, m_first, m_last, m_data}), exp_vec());
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Present one byte on requester i for exactly one clock edge.
    task automatic send(input int i, input bit f, input bit l, input logic [7:0] d);
        s_valid = '0;
        s_valid[i] = 1'b1;
        s_first[i] = f;
        s_last[i]  = l;
        s_data[8*i +: 8] = d;
        tick();
        s_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    int          pos [N];
    int          len [N];
    logic [N-1:0] rdy;
    int          seq_exp [6];

    initial begin
        seq_exp = '{0, 1, 0, 1, 0, 1};
        reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        repeat (3) tick();
        check("rst_grant", 32'(s_grant), 32'h0);
        check("rst_mvalid", 32'(m_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mdata", 32'(m_data), 32'h0);

        // ---- arbitration latency and a 4-byte frame from requester 0 ----
        reset = 1'b1;
        s_req = 2'b11;
        tick();
        check("arb_grant", 32'(s_grant), 32'h1);
        check("arb_ready", 32'(s_ready), 32'h1);
        check("arb_busy", 32'(busy), 32'h1);
        send(0, 1, 0, 8'h55);
        check("f4_b0_first", 32'({m_valid, m_first, m_last, m_data}), 32'h655);
        send(0, 0, 0, 8'h55);
        check("f4_b1", 32'({m_valid, m_first, m_last, m_data}), 32'h455);
        send(0, 0, 0, 8'hd5);
        check("f4_b2", 32'({m_valid, m_first, m_last, m_data}), 32'h4d5);
        send(0, 0, 1, 8'haa);
        check("f4_b3_last", 32'({m_valid, m_first, m_last, m_data}), 32'h5aa);
        check("f4_grant_drop", 32'(s_grant), 32'h0);
        tick();
        check("gap_mvalid_low", 32'(m_valid), 32'h0);
        check("gap_mdata_hold", 32'(m_data), 32'haa);
        repeat (11) tick();
        check("gap_no_grant", 32'(s_grant), 32'h0);
        tick();
        check("gap_next_grant", 32'(s_grant), 32'h2);

        // ---- 1-byte frame from requester 1 ----
        send(1, 1, 1, 8'h3c);
        check("f1_byte", 32'({m_valid, m_first, m_last, m_data}), 32'h73c);
        check("f1_grant_drop", 32'(s_grant), 32'h0);
        repeat (13) tick();
        check("f1_next_grant", 32'(s_grant), 32'h1);

        // ---- stall timeout in FORWARD ----
        send(0, 1, 0, 8'h11);
        check("tmo_b0", 32'(m_data), 32'h11);
        repeat (TMO) tick();
        check("tmo_not_yet", 32'({m_valid, abort}), 32'h0);
        check("tmo_still_granted", 32'(s_grant), 32'h1);
        tick();
        check("tmo_term", 32'({m_valid, m_first, m_last, m_data}), 32'h500);
        check("tmo_abort", 32'(abort), 32'h1);
        check("tmo_grant_drop", 32'(s_grant), 32'h0);
        tick();
        check("tmo_abort_pulse", 32'(abort), 32'h0);
        repeat (11) tick();
        check("tmo_gap", 32'(s_grant), 32'h0);
        tick();
        check("tmo_other_grant", 32'(s_grant), 32'h2);

        // ---- protocol error: first flag in mid-frame ----
        send(1, 1, 0, 8'h21);
        check("err_b0", 32'(m_data), 32'h21);
        send(1, 0, 0, 8'h22);
        check("err_b1", 32'(m_data), 32'h22);
        send(1, 1, 0, 8'h99);
        check("err_term", 32'({m_valid, m_first, m_last, m_data}), 32'h500);
        check("err_abort", 32'(abort), 32'h1);
        tick();
        check("err_mvalid_low", 32'({m_valid, abort}), 32'h0);
        repeat (12) tick();
        check("err_next_grant", 32'(s_grant), 32'h1);

        // ---- reset in FORWARD ----
        send(0, 1, 0, 8'h41);
        send(0, 0, 0, 8'h42);
        check("rstmid_b1", 32'({m_valid, m_data}), 32'h142);
        reset = 1'b0;
        model_reset();
        #1;
        check("rstmid_mvalid", 32'(m_valid), 32'h0);
        check("rstmid_grant", 32'(s_grant), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("rstmid_req0_wins", 32'(s_grant), 32'h1);

        // ---- round-robin fairness over 6 frames ----
        for (int f = 0; f < 6; f++) begin
            int budget;
            int idx;
            budget = 0;
            while (s_grant == '0 && budget < 40) begin
                tick();
                budget++;
            end
            check($sformatf("fair_grant_%0d", f), 32'(s_grant), 32'(1 << seq_exp[f]));
            if (s_grant != '0) begin
                idx = s_grant[1] ? 1 : 0;
                send(idx, 1, 0, 8'(8'h60 + f));
                send(idx, 0, 1, 8'(8'h70 + f));
            end
        end

        // ---- randomized traffic, checked by the model every cycle ----
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            len[i] = 1;
        end
        s_valid = '0;
        rdy = s_ready;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                reset = 1'b0;
                model_reset();
                repeat (2) tick();
                reset = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (s_valid[i] && rdy[i]) begin
                    if (s_last[i]) pos[i] = 0;
                    else pos[i]++;
                end
            end
            rdy = s_ready;
            for (int i = 0; i < N; i++) begin
                int r;
                if (!rdy[i]) pos[i] = 0;
                if (pos[i] == 0) len[i] = 1 + int'($urandom % 6);
                r = int'($urandom % 32);
                s_valid[i] = ($urandom % 4) != 0;
                if (pos[i] == 0 && r == 0) begin
                    s_first[i] = 1'b0;
                    s_last[i]  = 1'($urandom % 2);
                end else if (pos[i] > 0 && r == 1) begin
                    s_first[i] = 1'b1;
                    s_last[i]  = 1'b0;
                end else begin
                    s_first[i] = (pos[i] == 0);
                    s_last[i]  = (pos[i] == len[i] - 1);
                end
                s_data[8*i +: 8] = 8'($urandom);
                s_req[i] = ($urandom % 8) != 0;
            end
        end
        s_valid = '0;
        repeat (2) tick();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
